// File: rtl/traffic_phase_scheduler.sv
// Adaptive two-street traffic phase scheduler with a pedestrian walk phase.
// Green length adapts to queue occupancy between MIN_GREEN and MAX_GREEN.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 40,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2,
    parameter int PED_WALK  = 10,
    parameter int CNT_W     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] lastA,
    input  logic [7:0] lastB,
    input  logic       ped_req,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_AG  = 3'd0,
        S_AY  = 3'd1,
        S_AR  = 3'd2,
        S_BG  = 3'd3,
        S_BY  = 3'd4,
        S_BR  = 3'd5,
        S_PED = 3'd6,
        S_PC  = 3'd7
    } state_t;

    localparam logic DIR_A = 1'b0;
    localparam logic DIR_B = 1'b1;

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(PED_WALK - 1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pending_q, ped_pending_d;
    logic             last_dir_q, last_dir_d;
    logic [2:0]       a_q, b_q;
    logic             walk_q, ped_ack_q;

    logic [3:0] q_a, q_b;
    logic       ped_eff;
    logic       at_min, at_max;
    logic       is_green_d;
    logic [6:0] lamps_d;

    // Queue length is the position of the highest occupied slot, 1-based.
    function automatic logic [3:0] queue_len(input logic [7:0] v);
        logic [3:0] q;
        q = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) q = 4'(i + 1);
        end
        return q;
    endfunction

    // Packed as {A[2:0], B[2:0], walk}.
    function automatic logic [6:0] decode_lamps(input state_t s);
        logic [6:0] l;
        case (s)
            S_AG:    l = {L_GRN, L_RED, 1'b0};
            S_AY:    l = {L_YEL, L_RED, 1'b0};
            S_BG:    l = {L_RED, L_GRN, 1'b0};
            S_BY:    l = {L_RED, L_YEL, 1'b0};
            S_PED:   l = {L_RED, L_RED, 1'b1};
            default: l = {L_RED, L_RED, 1'b0};
        endcase
        return l;
    endfunction

    assign q_a     = queue_len(lastA);
    assign q_b     = queue_len(lastB);
    // A request arriving this cycle already counts toward this cycle's decision.
    assign ped_eff = ped_pending_q | ped_req;
    assign at_min  = (timer_q >= MIN_LAST);
    assign at_max  = (timer_q == MAX_LAST);

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        case (state_q)
            S_AG: begin
                last_dir_d = DIR_A;
                if (at_min && ((q_b > q_a) || ped_eff || (at_max && (q_b != 4'd0))))
                    state_d = S_AY;
            end
            S_AY: if (timer_q == YEL_LAST) state_d = S_AR;
            S_AR: if (timer_q == RED_LAST) state_d = ped_eff ? S_PED : S_BG;
            S_BG: begin
                last_dir_d = DIR_B;
                if (at_min && ((q_a > q_b) || ped_eff || (at_max && (q_a != 4'd0))))
                    state_d = S_BY;
            end
            S_BY: if (timer_q == YEL_LAST) state_d = S_BR;
            S_BR: if (timer_q == RED_LAST) state_d = ped_eff ? S_PED : S_AG;
            S_PED: if (timer_q == WALK_LAST) state_d = S_PC;
            S_PC: if (timer_q == RED_LAST) state_d = (last_dir_q == DIR_A) ? S_BG : S_AG;
            default: state_d = S_BR;
        endcase
    end

    assign is_green_d = (state_d == S_AG) || (state_d == S_BG);

    always_comb begin
        timer_d = timer_q + CNT_W'(1);
        if (state_d != state_q)
            timer_d = '0;
        else if (is_green_d && at_max)
            timer_d = timer_q;
    end

    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_d == S_PED)
            ped_pending_d = 1'b0;
        else if (ped_req && (state_q != S_PED))
            ped_pending_d = 1'b1;
    end

    assign lamps_d = decode_lamps(state_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BR;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
            last_dir_q    <= DIR_B;
            a_q           <= L_RED;
            b_q           <= L_RED;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
            last_dir_q    <= last_dir_d;
            a_q           <= lamps_d[6:4];
            b_q           <= lamps_d[3:1];
            walk_q        <= lamps_d[0];
            ped_ack_q     <= (state_d == S_PED) && (state_q != S_PED);
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign walk    = walk_q;
    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase-by-phase duration table
// plus a hand-written asynchronous reset in the middle of a walk phase.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_AG = 3'd0, P_AY = 3'd1, P_AR = 3'd2, P_BG = 3'd3;
    localparam logic [2:0] P_BY = 3'd4, P_BR = 3'd5, P_PED = 3'd6, P_PC = 3'd7;
    localparam int HOLD_BOUND = 60;

    logic       clock;
    logic       reset;
    logic [7:0] lastA, lastB;
    logic       ped_req;
    logic [2:0] A, B;
    logic       walk, ped_ack;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;
    int safety_viol = 0;

    traffic_phase_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .lastA   (lastA),
        .lastB   (lastB),
        .ped_req (ped_req),
        .A       (A),
        .B       (B),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if ((A != 3'b100 && B != 3'b100) || (walk && (A != 3'b100 || B != 3'b100))) begin
            safety_viol++;
            $display("FAIL safety A=%b B=%b walk=%b", A, B, walk);
        end
    end

    typedef struct {
        bit         rst;
        logic [7:0] la;
        logic [7:0] lb;
        int         ped_at;
        logic [2:0] ph;
        int         len;
        bit         hold;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t rrow(input logic [7:0] la, input logic [7:0] lb);
        vec_t v;
        v = '{rst: 1'b1, la: la, lb: lb, ped_at: -1, ph: 3'd0, len: 0, hold: 1'b0};
        return v;
    endfunction

    function automatic vec_t prow(input logic [2:0] ph, input int len, input bit hold, input int ped_at);
        vec_t v;
        v = '{rst: 1'b0, la: 8'h00, lb: 8'h00, ped_at: ped_at, ph: ph, len: len, hold: hold};
        return v;
    endfunction

    // Reference lamp pattern {A, B, walk} for each phase.
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            P_AG:    return 7'b001_100_0;
            P_AY:    return 7'b010_100_0;
            P_BG:    return 7'b100_001_0;
            P_BY:    return 7'b100_010_0;
            P_PED:   return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] la, input logic [7:0] lb, input string name);
        lastA   = la;
        lastB   = lb;
        ped_req = 1'b0;
        reset   = 1'b0;
        repeat (10) @(negedge clock);
        check({name, "_rst_lamps"}, {25'd0, A, B, walk}, 32'b100_100_0);
        check({name, "_rst_phase"}, {29'd0, phase}, 32'd5);
        check({name, "_rst_ack"}, {31'd0, ped_ack}, 32'd0);
        reset = 1'b1;
    endtask

    // Called at the sample point of the first cycle of a phase; returns at
    // the sample point of the first cycle of the following phase.
    task automatic run_phase(input logic [2:0] ph, input int len, input bit hold,
                             input int ped_at, input string name);
        int n, acks, ack_idx, walks, bound;
        n = 0; acks = 0; ack_idx = -1; walks = 0;
        bound = hold ? HOLD_BOUND : len + 20;
        check({name, "_phase"}, {29'd0, phase}, {29'd0, ph});
        check({name, "_lamps"}, {25'd0, A, B, walk}, {25'd0, exp_lamps(ph)});
        while (phase == ph && n < bound) begin
            ped_req = (n == ped_at);
            if (ped_ack) begin
                acks++;
                if (ack_idx < 0) ack_idx = n;
            end
            if (walk) walks++;
            n++;
            @(negedge clock);
        end
        ped_req = 1'b0;
        check({name, "_len"}, n, hold ? HOLD_BOUND : len);
        check({name, "_acks"}, acks, (ph == P_PED) ? 1 : 0);
        check({name, "_walks"}, walks, (ph == P_PED) ? n : 0);
        if (ph == P_PED) check({name, "_ack_first"}, ack_idx, 0);
    endtask

    initial begin
        reset   = 1'b0;
        lastA   = 8'h00;
        lastB   = 8'h00;
        ped_req = 1'b0;

        // Single-sided demand on B.
        tbl.push_back(rrow(8'b0000_0000, 8'b0000_0010));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 8, 0, -1));
        tbl.push_back(prow(P_AY, 4, 0, -1));
        tbl.push_back(prow(P_AR, 2, 0, -1));
        tbl.push_back(prow(P_BG, 0, 1, -1));
        // A-heavy demand: qA=4, qB=2.
        tbl.push_back(rrow(8'b0000_1000, 8'b0000_0010));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 40, 0, -1));
        tbl.push_back(prow(P_AY, 4, 0, -1));
        tbl.push_back(prow(P_AR, 2, 0, -1));
        tbl.push_back(prow(P_BG, 8, 0, -1));
        tbl.push_back(prow(P_BY, 4, 0, -1));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 40, 0, -1));
        // Equal demand alternates full-length greens.
        tbl.push_back(rrow(8'b0000_0010, 8'b0000_0010));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 40, 0, -1));
        tbl.push_back(prow(P_AY, 4, 0, -1));
        tbl.push_back(prow(P_AR, 2, 0, -1));
        tbl.push_back(prow(P_BG, 40, 0, -1));
        tbl.push_back(prow(P_BY, 4, 0, -1));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 40, 0, -1));
        // Pedestrian pulse at AG timer=3, second pulse mid-walk is ignored.
        tbl.push_back(rrow(8'b0000_0000, 8'b0000_0000));
        tbl.push_back(prow(P_BR, 2, 0, -1));
        tbl.push_back(prow(P_AG, 8, 0, 3));
        tbl.push_back(prow(P_AY, 4, 0, -1));
        tbl.push_back(prow(P_AR, 2, 0, -1));
        tbl.push_back(prow(P_PED, 10, 0, 4));
        tbl.push_back(prow(P_PC, 2, 0, -1));
        tbl.push_back(prow(P_BG, 0, 1, -1));

        @(negedge clock);
        foreach (tbl[i]) begin
            if (tbl[i].rst)
                do_reset(tbl[i].la, tbl[i].lb, $sformatf("row%0d", i));
            else
                run_phase(tbl[i].ph, tbl[i].len, tbl[i].hold, tbl[i].ped_at,
                          $sformatf("row%0d", i));
        end

        // Asynchronous reset during the walk phase.
        do_reset(8'h00, 8'h00, "midwalk");
        run_phase(P_BR, 2, 0, -1, "mw_br");
        run_phase(P_AG, 8, 0, 3, "mw_ag");
        run_phase(P_AY, 4, 0, -1, "mw_ay");
        run_phase(P_AR, 2, 0, -1, "mw_ar");
        check("mw_ped_entry", {29'd0, phase}, {29'd0, P_PED});
        check("mw_ped_walk", {31'd0, walk}, 32'd1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mw_async_phase", {29'd0, phase}, 32'd5);
        check("mw_async_lamps", {25'd0, A, B, walk}, 32'b100_100_0);
        check("mw_async_ack", {31'd0, ped_ack}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        run_phase(P_BR, 2, 0, -1, "mw_post_br");
        run_phase(P_AG, 0, 1, -1, "mw_post_ag_hold");

        check("safety", safety_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Adaptive phase scheduler for a two-street intersection with a pedestrian crossing.
- Reads per-street queue occupancy vectors lastA and lastB, plus a pedestrian request.
- Sequences green, yellow and all-red phases with minimum and maximum green times and a walk phase.
- Drives the A and B lamp buses and the walk signal; sits directly above the lamp drivers at intersection top level.

Parameters:
- MIN_GREEN, 8: minimum green duration in cycles (>=1).
- MAX_GREEN, 40: maximum green duration in cycles when the other street has demand (>=MIN_GREEN).
- YELLOW, 4: yellow duration in cycles (>=1).
- ALL_RED, 2: all-red clearance duration in cycles (>=1).
- PED_WALK, 10: walk phase duration in cycles (>=1).
- CNT_W, 8: phase timer width; must hold the largest duration minus 1.

Ports:
- clock, input, 1: single system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- lastA, input, 8: street A occupancy vector.
- lastB, input, 8: street B occupancy vector.
- ped_req, input, 1: pedestrian request; a level or a 1-cycle pulse is accepted.
- A, output, 3: street A lamps, one-hot {red, yellow, green} as bits [2:0].
- B, output, 3: street B lamps, same encoding as A.
- walk, output, 1: pedestrian walk lamp.
- ped_ack, output, 1: 1-cycle pulse on entry to the walk phase.
- phase, output, 3: current state encoding, for debug and verification.

Behaviour:
- Queue length qX = index of the highest set bit of lastX, plus 1.
  - qX = 0 when lastX = 0.
  - Examples: 00001000 -> 4, 00000010 -> 2, 00100000 -> 6.
  - Combinational, sampled every cycle; no latching.
- States and phase encoding:
  - AG=0, AY=1, AR=2, BG=3, BY=4, BR=5, PED=6, PC=7.
- Lamps and walk, decoded from the state register only (Moore):
  - AG: A=001, B=100.
  - AY: A=010, B=100.
  - BG: A=100, B=001.
  - BY: A=100, B=010.
  - AR, BR, PED, PC: A=100, B=100.
  - walk=1 only in PED.
- Timer:
  - Counts 0,1,2,... from entry to a state.
  - Cleared to 0 on every transition.
  - In green states it saturates at MAX_GREEN-1.
- ped_pending register:
  - Set on any cycle with ped_req=1 while the state is not PED.
  - Cleared on entry to PED; ped_req during PED is ignored.
- AG exit to AY, only when timer >= MIN_GREEN-1, if any of:
  - qB > qA;
  - ped_pending=1;
  - timer == MAX_GREEN-1 and (qB != 0 or ped_pending).
- AG hold:
  - If qB = 0 and ped_pending = 0, AG is held indefinitely.
  - Equal queues hold AG until MAX_GREEN.
- BG: symmetric to AG with A and B swapped.
- Fixed-length phases:
  - AY and BY last exactly YELLOW cycles.
  - AR, BR and PC last exactly ALL_RED cycles.
  - PED lasts exactly PED_WALK cycles.
- Next-state after clearance and walk:
  - AR -> PED if ped_pending, else BG.
  - BR -> PED if ped_pending, else AG.
  - PED -> PC.
  - PC -> the green of the street not served before the walk; a last_dir flag records the last green street.
- ped_ack:
  - Registered, high for exactly the first cycle in PED.
  - One ack per walk phase.
- Reset (asynchronous, active-low):
  - state=BR, timer=0, ped_pending=0, last_dir=B.
  - Outputs: A=100, B=100, walk=0, ped_ack=0, phase=5.
  - Takes effect immediately, including mid-PED or mid-yellow.
- After reset release:
  - BR lasts ALL_RED cycles, then the block enters AG.
- Safety invariant:
  - A and B are never both non-red.
  - walk=1 never coincides with a non-red lamp.
- Simultaneous events:
  - ped_req arriving in the same cycle as the AG exit decision is counted for that decision.
  - qX changing mid-yellow has no effect.

Test Plan:
- Reset and start-up: reset=0 for 10 cycles -> A=100, B=100, phase=5, walk=0. Release -> BR holds 2 cycles, then AG (A=001, B=100, phase=0).
- Single-sided demand: lastA=0, lastB=00000010.
  - AG lasts exactly 8 cycles, then AY (A=010) for 4 cycles, AR for 2, then BG (B=001).
  - BG is then held indefinitely while qA=0.
- A-heavy demand: lastA=00001000 (q=4), lastB=00000010 (q=2).
  - AG held 40 cycles, then AY/AR, then BG.
  - BG exits after 8 cycles since qA>qB.
- Equal demand: lastA=lastB=00000010 -> greens alternate, each exactly 40 cycles, with 4 yellow and 2 all-red cycles between.
- Pedestrian request: ped_req 1-cycle pulse at AG timer=3, no queue demand.
  - AG ends at cycle 8; AY 4 cycles, AR 2 cycles.
  - PED: ped_ack=1 for 1 cycle, walk=1 for 10 cycles.
  - PC 2 cycles, then BG.
  - A second ped_req during PED produces no extra walk phase.
- Reset mid-walk: reset=0 at PED cycle 5 -> walk=0, A=B=100, phase=5 in the same cycle (asynchronous), ped_pending cleared. After release -> AG after 2 cycles.
